// File: rtl/gf180mcu_fd_sc_mcu7t5v0__fillcap_seq.sv
// Switched decoupling-capacitance bank: brings SEGMENTS gated fillcap segments
// online/offline one at a time, one change every STEP_CYCLES clocks.
module gf180mcu_fd_sc_mcu7t5v0__fillcap_seq #(
    parameter int SEGMENTS    = 8,
    parameter int STEP_CYCLES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                HOLD,
    output logic [SEGMENTS-1:0] SEG_EN,
    output logic                READY,
    output logic                BUSY,
    inout  wire                 VDD,
    inout  wire                 VSS
);
    localparam int CW = $clog2(SEGMENTS + 1);
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SEGMENTS);
    localparam logic [TW-1:0] TMR_LAST = TW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

    state_t              r_state, w_state_next;
    logic [CW-1:0]       r_cnt, w_cnt_next, w_cnt_inc, w_cnt_dec;
    logic [TW-1:0]       r_tmr, w_tmr_next, w_tmr_inc;
    logic                w_tmr_done;
    logic [SEGMENTS-1:0] w_seg_next, r_seg;
    logic                r_ready, r_busy;

    // Rails are carried for cell-level connectivity only; no logic depends on them.
    wire w_unused_rails = VDD ^ VSS;

    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_cnt_dec  = r_cnt - CW'(1);
    assign w_tmr_inc  = r_tmr + TW'(1);
    assign w_tmr_done = (r_tmr == TMR_LAST);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_tmr_next   = r_tmr;
        if (!HOLD) begin
            case (r_state)
                S_OFF, S_UP: begin
                    if (EN) begin
                        // The OFF->UP edge is itself the first step cycle (tmr is 0 in OFF).
                        w_state_next = S_UP;
                        if (w_tmr_done) begin
                            w_tmr_next = '0;
                            w_cnt_next = w_cnt_inc;
                            if (w_cnt_inc == CNT_MAX) w_state_next = S_ON;
                        end else begin
                            w_tmr_next = w_tmr_inc;
                        end
                    end else if (r_state == S_UP) begin
                        // Reversal before any segment came on falls straight back to OFF.
                        w_tmr_next   = '0;
                        w_state_next = (r_cnt == '0) ? S_OFF : S_DOWN;
                    end
                end
                S_ON, S_DOWN: begin
                    if (!EN) begin
                        w_state_next = S_DOWN;
                        if (w_tmr_done) begin
                            w_tmr_next = '0;
                            w_cnt_next = w_cnt_dec;
                            if (w_cnt_dec == '0) w_state_next = S_OFF;
                        end else begin
                            w_tmr_next = w_tmr_inc;
                        end
                    end else if (r_state == S_DOWN) begin
                        // Reversal before any segment went off returns straight to ON.
                        w_tmr_next   = '0;
                        w_state_next = (r_cnt == CNT_MAX) ? S_ON : S_UP;
                    end
                end
                default: w_state_next = S_OFF;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SEGMENTS; gi++) begin : g_therm
            assign w_seg_next[gi] = (w_cnt_next > CW'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_seg   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_tmr   <= w_tmr_next;
            r_seg   <= w_seg_next;
            r_ready <= (w_state_next == S_ON);
            r_busy  <= (w_state_next == S_UP) || (w_state_next == S_DOWN);
        end
    end

    assign SEG_EN = r_seg;
    assign READY  = r_ready;
    assign BUSY   = r_busy;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__fillcap_seq.sv
// Scoreboard bench: three parameterisations share stimulus; a countdown-based
// reference model predicts each edge and a monitor compares after every edge.
module tb_gf180mcu_fd_sc_mcu7t5v0__fillcap_seq;
    localparam int N = 3;

    typedef struct packed {
        logic [N-1:0][31:0] seg;
        logic [N-1:0]       ready;
        logic [N-1:0]       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic hold = 1'b0;
    wire  vdd;
    wire  vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    logic [7:0]  seg0;
    logic [0:0]  seg1;
    logic [31:0] seg2;
    logic        rdy0, rdy1, rdy2, bsy0, bsy1, bsy2;

    gf180mcu_fd_sc_mcu7t5v0__fillcap_seq #(.SEGMENTS(8), .STEP_CYCLES(4)) dut0 (
        .CLK(clk), .RST(rst), .EN(en), .HOLD(hold),
        .SEG_EN(seg0), .READY(rdy0), .BUSY(bsy0), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu7t5v0__fillcap_seq #(.SEGMENTS(1), .STEP_CYCLES(1)) dut1 (
        .CLK(clk), .RST(rst), .EN(en), .HOLD(hold),
        .SEG_EN(seg1), .READY(rdy1), .BUSY(bsy1), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu7t5v0__fillcap_seq #(.SEGMENTS(32), .STEP_CYCLES(256)) dut2 (
        .CLK(clk), .RST(rst), .EN(en), .HOLD(hold),
        .SEG_EN(seg2), .READY(rdy2), .BUSY(bsy2), .VDD(vdd), .VSS(vss));

    always #5 clk = ~clk;

    // Reference model: segment count, cycles left before the next step, ramping flag and direction.
    int   segp[N];
    int   stepp[N];
    int   m_cnt[N];
    int   m_left[N];
    bit   m_busy[N];
    bit   m_up[N];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    task automatic tick(input int i);
        if (m_left[i] == 0) begin
            m_cnt[i]  = m_up[i] ? m_cnt[i] + 1 : m_cnt[i] - 1;
            m_left[i] = stepp[i] - 1;
            if (m_cnt[i] == 0 || m_cnt[i] == segp[i]) m_busy[i] = 1'b0;
        end else begin
            m_left[i] = m_left[i] - 1;
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit h);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_cnt[i] = 0; m_left[i] = 0; m_busy[i] = 1'b0;
            end else if (h) begin
            end else if (!m_busy[i]) begin
                if ((e && m_cnt[i] == 0) || (!e && m_cnt[i] == segp[i])) begin
                    m_busy[i] = 1'b1; m_up[i] = e; m_left[i] = stepp[i] - 1;
                    tick(i);
                end
            end else if (e != m_up[i]) begin
                m_up[i] = e; m_left[i] = stepp[i] - 1;
                if ((!e && m_cnt[i] == 0) || (e && m_cnt[i] == segp[i])) m_busy[i] = 1'b0;
            end else begin
                tick(i);
            end
        end
    endtask

    function automatic exp_t expect_now();
        exp_t   x;
        longint m;
        for (int i = 0; i < N; i++) begin
            m = (64'd1 << m_cnt[i]) - 64'd1;
            x.seg[i]   = m[31:0];
            x.ready[i] = !m_busy[i] && (m_cnt[i] == segp[i]);
            x.busy[i]  = m_busy[i];
        end
        return x;
    endfunction

    task automatic drive(input bit r, input bit e, input bit h, input int cycles);
        $display("phase @%0d: rst=%0b en=%0b hold=%0b for %0d cycles", cyc, r, e, h, cycles);
        repeat (cycles) begin
            @(negedge clk);
            rst = r; en = e; hold = h;
            model_edge(r, e, h);
            sb.push_back(expect_now());
        end
    endtask

    exp_t        mx;
    logic [31:0] a_seg;
    logic        a_rdy, a_bsy;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                mx = sb.pop_front();
                for (int i = 0; i < N; i++) begin
                    case (i)
                        0: begin a_seg = {24'd0, seg0}; a_rdy = rdy0; a_bsy = bsy0; end
                        1: begin a_seg = {31'd0, seg1}; a_rdy = rdy1; a_bsy = bsy1; end
                        default: begin a_seg = seg2; a_rdy = rdy2; a_bsy = bsy2; end
                    endcase
                    n_checks++;
                    if (a_seg !== mx.seg[i] || a_rdy !== mx.ready[i] || a_bsy !== mx.busy[i]) begin
                        n_fail++;
                        $display("FAIL dut%0d_outputs cyc %0d: got seg_en=%h ready=%b busy=%b, expected seg_en=%h ready=%b busy=%b",
                                 i, cyc, a_seg, a_rdy, a_bsy, mx.seg[i], mx.ready[i], mx.busy[i]);
                    end
                end
            end
        end
    end

    initial begin
        segp[0] = 8;  stepp[0] = 4;
        segp[1] = 1;  stepp[1] = 1;
        segp[2] = 32; stepp[2] = 256;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_left[i] = 0; m_busy[i] = 1'b0; m_up[i] = 1'b0;
        end
        drive(1, 1, 0, 2);      // reset held with EN high
        drive(0, 1, 0, 40);     // full ramp up
        drive(0, 0, 0, 40);     // full ramp down
        drive(0, 1, 0, 12);     // up to 0x07
        drive(0, 0, 0, 6);      // reversal down
        drive(0, 1, 0, 10);     // reversal up
        drive(0, 0, 0, 40);
        drive(0, 1, 0, 16);     // up to 0x0F
        drive(0, 1, 1, 10);     // hold mid-ramp
        drive(0, 1, 0, 24);
        drive(0, 0, 1, 3);      // hold wins over EN drop
        drive(0, 0, 0, 2);
        drive(1, 0, 0, 1);
        drive(0, 1, 0, 20);     // up to 0x1F
        drive(1, 1, 0, 1);      // reset mid-ramp
        drive(0, 1, 0, 10);
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 1);      // reversal on the first step cycle
        drive(0, 1, 0, 40);
        drive(0, 0, 0, 1);      // reversal from ON before first decrement
        drive(0, 1, 0, 3);
        repeat (150) begin
            drive($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0, $urandom_range(1, 20));
        end
        drive(1, 0, 0, 2);
        drive(0, 1, 0, 8300);   // deepest bank reaches READY
        drive(0, 0, 0, 8300);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
